// File: rtl/transmissao_serial_pkg.sv
// ---------------------------------------------------------------------------
// Module : transmissao_serial_pkg
// Brief  : State encoding and RAM geometry shared by the serial transmission
//          control unit.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package transmissao_serial_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL   = 4'd0,
        ST_PREPARA   = 4'd1,
        ST_LEITURA   = 4'd2,
        ST_ENVIA_B0  = 4'd3,
        ST_ESPERA_B0 = 4'd4,
        ST_GAP_B0    = 4'd5,
        ST_TROCA_B1  = 4'd6,
        ST_ENVIA_B1  = 4'd7,
        ST_ESPERA_B1 = 4'd8,
        ST_GAP_B1    = 4'd9,
        ST_TROCA_B0  = 4'd10,
        ST_PROXIMO   = 4'd11,
        ST_FIM       = 4'd12
    } estado_t;

    localparam int N_BYTES_PIXEL = 2;
    localparam int RAM_LINES     = 3;
    localparam int RAM_COLUMNS   = 3;

endpackage

`default_nettype wire

// File: rtl/transmissao_serial_uc_gap_timer.sv
// ---------------------------------------------------------------------------
// Module : gap_timer
// Brief  : Clearable up-counter that flags when it reaches its last count.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module gap_timer #(
    parameter int WIDTH = 8,
    parameter int LAST  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == WIDTH'(LAST));

endmodule

`default_nettype wire

// File: rtl/transmissao_serial_uc.sv
// ---------------------------------------------------------------------------
// Module : transmissao_serial_uc
// Brief  : Moore control unit streaming a 3x3 RAM of 16-bit pixels as
//          18 UART frames, then pulsing pronto.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module transmissao_serial_uc
    import transmissao_serial_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int GAP_W      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pronto_uart,
    input  logic       shift_serial,
    input  logic       fim_coluna,
    input  logic       fim_linha,
    output logic       partida_serial,
    output logic       flipa,
    output logic       zera_linha,
    output logic       zera_coluna,
    output logic       conta_linha,
    output logic       conta_coluna,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    logic    r_partida;
    logic    r_flipa;
    logic    r_zera_linha;
    logic    r_zera_coluna;
    logic    r_conta_linha;
    logic    r_conta_coluna;
    logic    r_pronto;
    logic    w_gap_done;

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            gap_timer #(
                .WIDTH (GAP_W),
                .LAST  (GAP_CYCLES - 1)
            ) u_gap_timer (
                .clk      (clock),
                .rst      (reset),
                .i_clear  ((r_estado == ST_ESPERA_B0) || (r_estado == ST_ESPERA_B1)),
                .i_enable ((r_estado == ST_GAP_B0) || (r_estado == ST_GAP_B1)),
                .o_done   (w_gap_done)
            );
        end else begin : g_no_gap
            assign w_gap_done = 1'b1;
        end
    endgenerate

    // Outputs are registered alongside the state they belong to, so each one
    // is high exactly for the cycle its state is occupied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado       <= ST_INICIAL;
            r_partida      <= 1'b0;
            r_flipa        <= 1'b0;
            r_zera_linha   <= 1'b0;
            r_zera_coluna  <= 1'b0;
            r_conta_linha  <= 1'b0;
            r_conta_coluna <= 1'b0;
            r_pronto       <= 1'b0;
        end else begin
            r_partida      <= 1'b0;
            r_flipa        <= 1'b0;
            r_zera_linha   <= 1'b0;
            r_zera_coluna  <= 1'b0;
            r_conta_linha  <= 1'b0;
            r_conta_coluna <= 1'b0;
            r_pronto       <= 1'b0;
            case (r_estado)
                ST_INICIAL: begin
                    if (iniciar) begin
                        r_estado      <= ST_PREPARA;
                        r_zera_linha  <= 1'b1;
                        r_zera_coluna <= 1'b1;
                        // Byte-select flip-flop has no reset; realign it here.
                        r_flipa       <= shift_serial;
                    end
                end
                ST_PREPARA: r_estado <= ST_LEITURA;
                ST_LEITURA: begin
                    r_estado  <= ST_ENVIA_B0;
                    r_partida <= 1'b1;
                end
                ST_ENVIA_B0: r_estado <= ST_ESPERA_B0;
                ST_ESPERA_B0: begin
                    if (pronto_uart) begin
                        if (GAP_CYCLES == 0) begin
                            r_estado <= ST_TROCA_B1;
                            r_flipa  <= 1'b1;
                        end else begin
                            r_estado <= ST_GAP_B0;
                        end
                    end
                end
                ST_GAP_B0: begin
                    if (w_gap_done) begin
                        r_estado <= ST_TROCA_B1;
                        r_flipa  <= 1'b1;
                    end
                end
                ST_TROCA_B1: begin
                    r_estado  <= ST_ENVIA_B1;
                    r_partida <= 1'b1;
                end
                ST_ENVIA_B1: r_estado <= ST_ESPERA_B1;
                ST_ESPERA_B1: begin
                    if (pronto_uart) begin
                        if (GAP_CYCLES == 0) begin
                            r_estado <= ST_TROCA_B0;
                            r_flipa  <= 1'b1;
                        end else begin
                            r_estado <= ST_GAP_B1;
                        end
                    end
                end
                ST_GAP_B1: begin
                    if (w_gap_done) begin
                        r_estado <= ST_TROCA_B0;
                        r_flipa  <= 1'b1;
                    end
                end
                ST_TROCA_B0: begin
                    r_estado       <= ST_PROXIMO;
                    r_conta_coluna <= ~(fim_coluna & fim_linha);
                    r_conta_linha  <= fim_coluna & ~fim_linha;
                end
                ST_PROXIMO: begin
                    if (fim_coluna && fim_linha) begin
                        r_estado <= ST_FIM;
                        r_pronto <= 1'b1;
                    end else begin
                        r_estado <= ST_LEITURA;
                    end
                end
                ST_FIM:  r_estado <= ST_INICIAL;
                default: r_estado <= ST_INICIAL;
            endcase
        end
    end

    assign partida_serial = r_partida;
    assign flipa          = r_flipa;
    assign zera_linha     = r_zera_linha;
    assign zera_coluna    = r_zera_coluna;
    assign conta_linha    = r_conta_linha;
    assign conta_coluna   = r_conta_coluna;
    assign pronto         = r_pronto;
    assign db_estado      = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_transmissao_serial_uc.sv
// ---------------------------------------------------------------------------
// Module : tb_transmissao_serial_uc
// Brief  : Directed bench for the control unit with GAP_CYCLES=0 and 5,
//          each driving a behavioural datapath (counters, T flip-flop, UART).
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_transmissao_serial_uc;

    localparam int GAP1 = 5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0] iniciar, pronto_uart, shift_serial, fim_coluna, fim_linha;
    logic [1:0] partida, flipa, zl, zc, cl, cc, pronto;
    logic [1:0][3:0] db;

    transmissao_serial_uc #(.GAP_CYCLES(0), .GAP_W(8)) dut0 (
        .clock(clock), .reset(reset), .iniciar(iniciar[0]), .pronto_uart(pronto_uart[0]),
        .shift_serial(shift_serial[0]), .fim_coluna(fim_coluna[0]), .fim_linha(fim_linha[0]),
        .partida_serial(partida[0]), .flipa(flipa[0]), .zera_linha(zl[0]), .zera_coluna(zc[0]),
        .conta_linha(cl[0]), .conta_coluna(cc[0]), .pronto(pronto[0]), .db_estado(db[0]));

    transmissao_serial_uc #(.GAP_CYCLES(GAP1), .GAP_W(8)) dut5 (
        .clock(clock), .reset(reset), .iniciar(iniciar[1]), .pronto_uart(pronto_uart[1]),
        .shift_serial(shift_serial[1]), .fim_coluna(fim_coluna[1]), .fim_linha(fim_linha[1]),
        .partida_serial(partida[1]), .flipa(flipa[1]), .zera_linha(zl[1]), .zera_coluna(zc[1]),
        .conta_linha(cl[1]), .conta_coluna(cc[1]), .pronto(pronto[1]), .db_estado(db[1]));

    // Behavioural datapath: counters and flip-flop deliberately ignore reset.
    logic [1:0] ff = 2'b00;
    logic [1:0] preset = 2'b00;
    logic [1:0] spur_en = 2'b00;
    int lin [2];
    int col [2];
    int ucnt [2];

    always @(posedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (preset[g]) ff[g] <= 1'b1;
            else if (flipa[g]) ff[g] <= ~ff[g];
            if (zc[g]) col[g] <= 0;
            else if (cc[g]) col[g] <= (col[g] == 2) ? 0 : col[g] + 1;
            if (zl[g]) lin[g] <= 0;
            else if (cl[g]) lin[g] <= lin[g] + 1;
            if (partida[g]) ucnt[g] <= 10;
            else if (ucnt[g] != 0) ucnt[g] <= ucnt[g] - 1;
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            shift_serial[g] = ff[g];
            fim_coluna[g]   = (col[g] == 2);
            fim_linha[g]    = (lin[g] == 2);
            pronto_uart[g]  = (ucnt[g] == 1) || (spur_en[g] && db[g] == 4'd2);
        end
    end

    // Event statistics, sampled on the falling edge.
    int n_part [2], n_flip [2], n_cc [2], n_cl [2], n_pronto [2], n_active [2];
    int n_prep_flip [2], n_busy [2], n_gap [2], n_gap_bad [2], n_spur [2], gap_dist [2];
    bit gap_run [2];
    int plog [2][256];

    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (partida[g]) begin
                if (n_part[g] < 256) plog[g][n_part[g]] <= lin[g] * 100 + col[g] * 10 + int'(ff[g]);
                n_part[g] <= n_part[g] + 1;
                if (ucnt[g] != 0) n_busy[g] <= n_busy[g] + 1;
            end
            if (flipa[g]) n_flip[g] <= n_flip[g] + 1;
            if (flipa[g] && db[g] == 4'd1) n_prep_flip[g] <= n_prep_flip[g] + 1;
            if (cc[g]) n_cc[g] <= n_cc[g] + 1;
            if (cl[g]) n_cl[g] <= n_cl[g] + 1;
            if (pronto[g]) n_pronto[g] <= n_pronto[g] + 1;
            if (db[g] != 4'd0) n_active[g] <= n_active[g] + 1;
            if (spur_en[g] && db[g] == 4'd2) n_spur[g] <= n_spur[g] + 1;
            if (reset) begin
                gap_run[g] <= 1'b0;
            end else if (ucnt[g] == 1 && (db[g] == 4'd4 || db[g] == 4'd8)) begin
                gap_run[g]  <= 1'b1;
                gap_dist[g] <= 0;
            end else if (gap_run[g] && flipa[g]) begin
                n_gap[g] <= n_gap[g] + 1;
                if (gap_dist[g] + 1 != ((g == 0) ? 1 : GAP1 + 1)) n_gap_bad[g] <= n_gap_bad[g] + 1;
                gap_run[g] <= 1'b0;
            end else if (gap_run[g]) begin
                gap_dist[g] <= gap_dist[g] + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic logic [10:0] outs(input int g);
        return {partida[g], flipa[g], zl[g], zc[g], cl[g], cc[g], pronto[g], db[g]};
    endfunction

    // Number of logged partida samples disagreeing with row-major pixel order.
    function automatic int order_errs(input int g, input int base, input int n);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            int p = (k % 18) / 2;
            if (plog[g][base + k] != (p / 3) * 100 + (p % 3) * 10 + (k % 2)) e++;
        end
        return e;
    endfunction

    task automatic run_pass(input int g);
        int p0 = n_pronto[g];
        int used = 0;
        @(negedge clock); iniciar[g] = 1'b1;
        @(negedge clock); iniciar[g] = 1'b0;
        while (n_pronto[g] == p0 && used < 1000) begin
            @(negedge clock); #1; used++;
        end
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        int bad [2];
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (outs(g) !== 11'd0) begin
                errors++; $display("FAIL reset_held dut%0d got %h want 000", g, outs(g));
            end
        end
        reset = 1'b0;
        bad = '{0, 0};
        repeat (20) begin
            @(negedge clock); #1;
            for (int g = 0; g < 2; g++) if (outs(g) !== 11'd0) bad[g]++;
        end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (bad[g] !== 0) begin
                errors++; $display("FAIL idle_stable dut%0d nonzero_cycles %0d want 0", g, bad[g]);
            end
        end
    endtask

    task automatic test_pass;
        int s_part = n_part[0], s_flip = n_flip[0], s_cc = n_cc[0], s_cl = n_cl[0];
        int s_pr = n_pronto[0], s_act = n_active[0], s_pf = n_prep_flip[0];
        int s_busy = n_busy[0], s_gap = n_gap[0], s_gbad = n_gap_bad[0];
        int e;
        run_pass(0);
        checks++; if (n_part[0] - s_part !== 18) begin errors++; $display("FAIL pass_partida got %0d want 18", n_part[0] - s_part); end
        checks++; if (n_flip[0] - s_flip !== 18) begin errors++; $display("FAIL pass_flipa got %0d want 18", n_flip[0] - s_flip); end
        checks++; if (n_cc[0] - s_cc !== 8) begin errors++; $display("FAIL pass_conta_coluna got %0d want 8", n_cc[0] - s_cc); end
        checks++; if (n_cl[0] - s_cl !== 2) begin errors++; $display("FAIL pass_conta_linha got %0d want 2", n_cl[0] - s_cl); end
        checks++; if (n_pronto[0] - s_pr !== 1) begin errors++; $display("FAIL pass_pronto got %0d want 1", n_pronto[0] - s_pr); end
        checks++; if (n_active[0] - s_act !== 236) begin errors++; $display("FAIL pass_length got %0d want 236", n_active[0] - s_act); end
        checks++; if (n_prep_flip[0] - s_pf !== 0) begin errors++; $display("FAIL pass_prep_flipa got %0d want 0", n_prep_flip[0] - s_pf); end
        checks++; if (n_busy[0] - s_busy !== 0) begin errors++; $display("FAIL pass_partida_busy got %0d want 0", n_busy[0] - s_busy); end
        checks++; if (n_gap[0] - s_gap !== 18 || n_gap_bad[0] - s_gbad !== 0) begin
            errors++; $display("FAIL pass_gap0 gaps %0d bad %0d want 18 0", n_gap[0] - s_gap, n_gap_bad[0] - s_gbad);
        end
        e = order_errs(0, s_part, 18);
        checks++; if (e !== 0) begin errors++; $display("FAIL pass_order mismatches %0d want 0", e); end
    endtask

    task automatic test_preset;
        int s_part = n_part[0], s_flip = n_flip[0], s_pf = n_prep_flip[0];
        int e;
        @(negedge clock); preset[0] = 1'b1;
        @(negedge clock); preset[0] = 1'b0;
        run_pass(0);
        checks++; if (n_prep_flip[0] - s_pf !== 1) begin errors++; $display("FAIL preset_prep_flipa got %0d want 1", n_prep_flip[0] - s_pf); end
        checks++; if (n_flip[0] - s_flip !== 19) begin errors++; $display("FAIL preset_flipa got %0d want 19", n_flip[0] - s_flip); end
        checks++; if (plog[0][s_part] !== 0) begin errors++; $display("FAIL preset_first_byte got %0d want 0", plog[0][s_part]); end
        e = order_errs(0, s_part, 18);
        checks++; if (e !== 0) begin errors++; $display("FAIL preset_order mismatches %0d want 0", e); end
    endtask

    task automatic test_gap;
        int s_part = n_part[1], s_flip = n_flip[1], s_pr = n_pronto[1], s_act = n_active[1];
        int s_gap = n_gap[1], s_gbad = n_gap_bad[1];
        int e;
        run_pass(1);
        checks++; if (n_part[1] - s_part !== 18) begin errors++; $display("FAIL gap_partida got %0d want 18", n_part[1] - s_part); end
        checks++; if (n_flip[1] - s_flip !== 18) begin errors++; $display("FAIL gap_flipa got %0d want 18", n_flip[1] - s_flip); end
        checks++; if (n_pronto[1] - s_pr !== 1) begin errors++; $display("FAIL gap_pronto got %0d want 1", n_pronto[1] - s_pr); end
        checks++; if (n_active[1] - s_act !== 326) begin errors++; $display("FAIL gap_length got %0d want 326", n_active[1] - s_act); end
        checks++; if (n_gap[1] - s_gap !== 18) begin errors++; $display("FAIL gap_count got %0d want 18", n_gap[1] - s_gap); end
        checks++; if (n_gap_bad[1] - s_gbad !== 0) begin errors++; $display("FAIL gap_idle_cycles wrong %0d want 0", n_gap_bad[1] - s_gbad); end
        e = order_errs(1, s_part, 18);
        checks++; if (e !== 0) begin errors++; $display("FAIL gap_order mismatches %0d want 0", e); end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        int used = 0;
        int s_part, s_pr, s_pf;
        int e;
        @(negedge clock); iniciar[0] = 1'b1;
        @(negedge clock); iniciar[0] = 1'b0;
        while (!found && used < 1000) begin
            @(negedge clock); #1; used++;
            if (db[0] == 4'd8 && lin[0] == 1 && col[0] == 1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midreset_reach got 0 want 1"); end
        reset = 1'b1;
        #1;
        checks++; if (outs(0) !== 11'd0) begin errors++; $display("FAIL midreset_outputs got %h want 000", outs(0)); end
        @(negedge clock); reset = 1'b0;
        repeat (15) @(negedge clock);
        #1;
        checks++; if (outs(0) !== 11'd0) begin errors++; $display("FAIL midreset_idle got %h want 000", outs(0)); end
        s_part = n_part[0]; s_pr = n_pronto[0]; s_pf = n_prep_flip[0];
        run_pass(0);
        checks++; if (n_part[0] - s_part !== 18) begin errors++; $display("FAIL restart_partida got %0d want 18", n_part[0] - s_part); end
        checks++; if (n_pronto[0] - s_pr !== 1) begin errors++; $display("FAIL restart_pronto got %0d want 1", n_pronto[0] - s_pr); end
        checks++; if (n_prep_flip[0] - s_pf !== 1) begin errors++; $display("FAIL restart_realign got %0d want 1", n_prep_flip[0] - s_pf); end
        e = order_errs(0, s_part, 18);
        checks++; if (e !== 0) begin errors++; $display("FAIL restart_order mismatches %0d want 0", e); end
    endtask

    task automatic test_back_to_back;
        int s_part = n_part[0], s_pr = n_pronto[0], s_act = n_active[0];
        int s_busy = n_busy[0], s_spur = n_spur[0];
        int used = 0;
        int e;
        spur_en[0] = 1'b1;
        @(negedge clock); iniciar[0] = 1'b1;
        while (n_pronto[0] - s_pr < 2 && used < 2000) begin
            @(negedge clock); #1; used++;
        end
        iniciar[0] = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        spur_en[0] = 1'b0;
        checks++; if (n_pronto[0] - s_pr !== 2) begin errors++; $display("FAIL b2b_pronto got %0d want 2", n_pronto[0] - s_pr); end
        checks++; if (n_part[0] - s_part !== 36) begin errors++; $display("FAIL b2b_partida got %0d want 36", n_part[0] - s_part); end
        checks++; if (n_active[0] - s_act !== 472) begin errors++; $display("FAIL b2b_length got %0d want 472", n_active[0] - s_act); end
        checks++; if (n_spur[0] - s_spur !== 18) begin errors++; $display("FAIL b2b_spurious got %0d want 18", n_spur[0] - s_spur); end
        checks++; if (n_busy[0] - s_busy !== 0) begin errors++; $display("FAIL b2b_partida_busy got %0d want 0", n_busy[0] - s_busy); end
        e = order_errs(0, s_part, 36);
        checks++; if (e !== 0) begin errors++; $display("FAIL b2b_order mismatches %0d want 0", e); end
    endtask

    initial begin
        iniciar = 2'b00;
        reset   = 1'b0;
        test_reset();
        test_pass();
        test_preset();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
